ifu_fetch: RTL and testbench

- Instruction fetch unit of the multi-cycle RISC-V core, and the transmitting end of the fetch-to-decode handshake.
- Holds the architectural PC and reads one instruction word over an AXI4-Lite read channel.
- Presents {instruction, pc} to the decode unit under valid/ready, then waits for decode's PC update (pc_next, pc_write_enable) before starting the next fetch.
- Also provides a sticky fetch-error flag, a bus watchdog and a retired-fetch counter.

---
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, reads one word over AXI4-Lite, hands {instruction, pc}
// to decode under valid/ready, then waits for decode's PC update before fetching again.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  input  logic        ifu_receive_ready,
  output logic        ifu_send_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {StBoot, StAr, StR, StSend, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  logic in_bus, take_ar, take_r, timeout, xfer, pc_load;

  assign in_bus  = (state_q == StAr) || (state_q == StR);
  assign take_ar = (state_q == StAr) && arready;
  assign take_r  = (state_q == StR) && rvalid;
  assign xfer    = (state_q == StSend) && ifu_receive_ready;
  assign pc_load = pc_write_enable && (xfer || (state_q == StWait));
  // A bus event in the expiry cycle wins; the watchdog only fires while the FSM would stay put.
  assign timeout = (TIMEOUT != 0) && in_bus && !take_ar && !take_r &&
                   ((wdog_q + 32'd1) >= 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      count_q <= 32'd0;
      wdog_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StAr;
      StAr: begin
        if (take_ar)      state_d = StR;
        else if (timeout) state_d = StSend;
      end
      StR: begin
        if (take_r || timeout) state_d = StSend;
      end
      StSend: begin
        if (xfer) state_d = pc_write_enable ? StAr : StWait;
      end
      StWait: begin
        if (pc_write_enable) state_d = StAr;
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_d    = pc_load ? pc_next : pc_q;
    count_d = count_q + {31'd0, xfer};
    // Counter is zero whenever the FSM is outside the bus phase, so it starts clean on each S_AR.
    wdog_d  = in_bus ? (wdog_q + 32'd1) : 32'd0;
    instr_d = instr_q;
    err_d   = err_q;
    if (take_r) begin
      instr_d = (rresp == 2'b00) ? rdata : ERR_INST;
      if (rresp != 2'b00) err_d = 1'b1;
    end else if (timeout) begin
      instr_d = ERR_INST;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    arvalid        = (state_q == StAr);
    rready         = (state_q == StR);
    ifu_send_valid = (state_q == StSend);
    araddr         = pc_q;
    pc             = pc_q;
    instruction    = instr_q;
    fetch_error    = err_q;
    fetch_count    = count_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle table for the directed corners, then randomized fetches scored
// at transaction level against what the bench's bus slave and decode model did.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] ERR    = 32'h0010_0073;
  localparam int unsigned TMO    = 8;

  localparam logic [3:0] IDLE = 4'b0000, AR = 4'b1000, RV = 4'b0100, RDY = 4'b0010,
                         PCW = 4'b0001;
  localparam logic [2:0] HS_N = 3'b000, HS_AR = 3'b100, HS_R = 3'b010, HS_S = 3'b001;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_next = 32'd0, rdata = 32'd0;
  logic        pc_write_enable = 1'b0, ifu_receive_ready = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  rresp = 2'd0;
  logic        ifu_send_valid, arvalid, rready, fetch_error;
  logic [31:0] instruction, pc, araddr, fetch_count;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .ERR_INST(ERR)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .pc_write_enable(pc_write_enable),
    .ifu_receive_ready(ifu_receive_ready), .ifu_send_valid(ifu_send_valid),
    .instruction(instruction), .pc(pc), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fetch_error(fetch_error), .fetch_count(fetch_count)
  );

  typedef struct {
    logic [3:0]  ctl;  // {arready, rvalid, ifu_receive_ready, pc_write_enable}
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] pcn;
    logic [2:0]  e_hs; // {arvalid, rready, ifu_send_valid}
    logic [31:0] e_pc, e_ins, e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[29];
  int   total = 0, bad = 0;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rd, input logic [1:0] rr,
                              input logic [31:0] pcn, input logic [2:0] hs, input logic [31:0] epc,
                              input logic [31:0] eins, input logic [31:0] ecnt, input logic eerr);
    vec_t v;
    v.ctl = ctl; v.rdata = rd; v.rresp = rr; v.pcn = pcn; v.e_hs = hs;
    v.e_pc = epc; v.e_ins = eins; v.e_cnt = ecnt; v.e_err = eerr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] obs();
    return 160'({arvalid, rready, ifu_send_valid, araddr, pc, instruction, fetch_count,
                 fetch_error});
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic        exp_err;

    tbl[0]  = mk(IDLE,     32'h0,        2'd0, 32'h0,        HS_AR, RST_PC,       32'h0,        32'd0, 1'b0);
    tbl[1]  = mk(AR,       32'h0,        2'd0, 32'h0,        HS_R,  RST_PC,       32'h0,        32'd0, 1'b0);
    tbl[2]  = mk(RV,       32'h0000_0513, 2'd0, 32'h0,       HS_S,  RST_PC,       32'h0000_0513, 32'd0, 1'b0);
    tbl[3]  = mk(PCW,      32'h0,        2'd0, 32'hdead_bee0, HS_S, RST_PC,       32'h0000_0513, 32'd0, 1'b0);
    for (int i = 4; i < 7; i++)
      tbl[i] = mk(IDLE,    32'h0,        2'd0, 32'h0,        HS_S,  RST_PC,       32'h0000_0513, 32'd0, 1'b0);
    tbl[7]  = mk(RDY,      32'h0,        2'd0, 32'h0,        HS_N,  RST_PC,       32'h0000_0513, 32'd1, 1'b0);
    tbl[8]  = mk(IDLE,     32'h0,        2'd0, 32'h0,        HS_N,  RST_PC,       32'h0000_0513, 32'd1, 1'b0);
    tbl[9]  = tbl[8];
    tbl[10] = mk(PCW,      32'h0,        2'd0, 32'h8000_0010, HS_AR, 32'h8000_0010, 32'h0000_0513, 32'd1, 1'b0);
    tbl[11] = mk(AR,       32'h0,        2'd0, 32'h0,        HS_R,  32'h8000_0010, 32'h0000_0513, 32'd1, 1'b0);
    tbl[12] = mk(RV,       32'h00a0_0593, 2'd0, 32'h0,       HS_S,  32'h8000_0010, 32'h00a0_0593, 32'd1, 1'b0);
    tbl[13] = mk(RDY|PCW,  32'h0,        2'd0, 32'h8000_0004, HS_AR, 32'h8000_0004, 32'h00a0_0593, 32'd2, 1'b0);
    tbl[14] = mk(AR,       32'h0,        2'd0, 32'h0,        HS_R,  32'h8000_0004, 32'h00a0_0593, 32'd2, 1'b0);
    tbl[15] = mk(RV,       32'hdead_beef, 2'd2, 32'h0,       HS_S,  32'h8000_0004, ERR,          32'd2, 1'b1);
    tbl[16] = mk(RDY|PCW,  32'h0,        2'd0, 32'h8000_0008, HS_AR, 32'h8000_0008, ERR,          32'd3, 1'b1);
    tbl[17] = mk(AR,       32'h0,        2'd0, 32'h0,        HS_R,  32'h8000_0008, ERR,          32'd3, 1'b1);
    tbl[18] = mk(RV,       32'h0000_0013, 2'd0, 32'h0,       HS_S,  32'h8000_0008, 32'h0000_0013, 32'd3, 1'b1);
    tbl[19] = mk(RDY|PCW,  32'h0,        2'd0, 32'h8000_000c, HS_AR, 32'h8000_000c, 32'h0000_0013, 32'd4, 1'b1);
    // Seven more S_AR cycles with arready low (eight in total), one of them with a stray PC strobe.
    for (int i = 20; i < 27; i++)
      tbl[i] = mk(IDLE,    32'h0,        2'd0, 32'h0,        HS_AR, 32'h8000_000c, 32'h0000_0013, 32'd4, 1'b1);
    tbl[21] = mk(PCW,      32'h0,        2'd0, 32'h1234_5678, HS_AR, 32'h8000_000c, 32'h0000_0013, 32'd4, 1'b1);
    tbl[27] = mk(IDLE,     32'h0,        2'd0, 32'h0,        HS_S,  32'h8000_000c, ERR,          32'd4, 1'b1);
    tbl[28] = mk(RDY,      32'h0,        2'd0, 32'h0,        HS_N,  32'h8000_000c, ERR,          32'd5, 1'b1);

    rst = 1'b1;
    step();
    step();
    chk("reset", obs(), 160'({3'b000, RST_PC, RST_PC, 32'h0, 32'h0, 1'b0}));
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      {arready, rvalid, ifu_receive_ready, pc_write_enable} = tbl[i].ctl;
      rdata   = tbl[i].rdata;
      rresp   = tbl[i].rresp;
      pc_next = tbl[i].pcn;
      step();
      chk($sformatf("vec%0d", i), obs(),
          160'({tbl[i].e_hs, tbl[i].e_pc, tbl[i].e_pc, tbl[i].e_ins, tbl[i].e_cnt, tbl[i].e_err}));
    end
    {arready, rvalid, ifu_receive_ready, pc_write_enable} = IDLE;
    rresp = 2'd0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc  = RST_PC;
    exp_err = 1'b0;

    for (int k = 0; k < 40; k++) begin
      int unsigned ard, rd, stall, hold, gap;
      int          n;
      logic [31:0] word, npc, exp_ins;
      logic [1:0]  resp;
      ard   = $urandom_range(0, 2);
      rd    = $urandom_range(0, 2);
      stall = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0; // 1: no arready, 2: no rvalid
      word  = $urandom;
      resp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;

      n = 0;
      while (!arvalid && n < 4) begin step(); n++; end
      chk("rnd_arvalid", 160'(arvalid), 160'(1'b1));
      chk("rnd_araddr", 160'(araddr), 160'(exp_pc));

      if (stall != 1) begin
        repeat (ard) step();
        arready = 1'b1;
        step();
        arready = 1'b0;
        if (stall == 0) begin
          repeat (rd) step();
          rvalid = 1'b1; rdata = word; rresp = resp;
          step();
          rvalid = 1'b0; rresp = 2'd0;
        end
      end

      n = 0;
      while (!ifu_send_valid && n < 12) begin step(); n++; end
      exp_ins = (stall != 0 || resp != 2'd0) ? ERR : word;
      if (stall != 0 || resp != 2'd0) exp_err = 1'b1;
      chk("rnd_send", 160'({ifu_send_valid, instruction, pc, fetch_error, fetch_count}),
          160'({1'b1, exp_ins, exp_pc, exp_err, 32'(k)}));

      hold = $urandom_range(0, 2);
      repeat (hold) step();
      chk("rnd_hold", 160'({ifu_send_valid, instruction, pc}), 160'({1'b1, exp_ins, exp_pc}));

      npc = $urandom;
      ifu_receive_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        pc_write_enable = 1'b1; pc_next = npc;
        step();
        ifu_receive_ready = 1'b0; pc_write_enable = 1'b0;
        chk("rnd_direct", 160'({arvalid, araddr}), 160'({1'b1, npc}));
      end else begin
        step();
        ifu_receive_ready = 1'b0;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          chk("rnd_wait", 160'({arvalid, ifu_send_valid}), 160'(2'b00));
          step();
        end
        chk("rnd_wait", 160'({arvalid, ifu_send_valid}), 160'(2'b00));
        pc_write_enable = 1'b1; pc_next = npc;
        step();
        pc_write_enable = 1'b0;
        chk("rnd_pcwe", 160'({arvalid, araddr}), 160'({1'b1, npc}));
      end
      chk("rnd_count", 160'(fetch_count), 160'(32'(k + 1)));
      exp_pc = npc;
    end

    // Reset while a read is outstanding in S_R.
    arready = 1'b1;
    step();
    arready = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_reset", obs(), 160'({3'b000, RST_PC, RST_PC, 32'h0, 32'h0, 1'b0}));
    rst = 1'b0;
    step();
    chk("mid_reset_boot", 160'({arvalid, araddr}), 160'({1'b1, RST_PC}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
